// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS controller: main FSM state
// encoding, opcode constants, ALU-op codes (shared with the ALU decoder),
// the bundle of datapath controls, and the per-state control decode.
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

    localparam int OPW = 6;

    // Main control states, 4-bit encoding; 14..15 are unreachable.
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        ORIEX   = 4'd11,
        ORIWB   = 4'd12,
        JEX     = 4'd13
    } statetype;

    // Opcodes (instr[31:26])
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;

    // ALU operation requests to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    // Moore control bundle produced by every state
    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       zeroext;
    } ctrl_t;

    // Control values asserted while sitting in state s; everything not
    // named for a state stays 0.
    function automatic ctrl_t state_ctrl(input statetype s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
                c.alusrcb = 2'b01;
            end
            DECODE: begin
                c.alusrcb = 2'b11;
            end
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD: begin
                c.iord = 1'b1;
            end
            MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            RTYPEEX: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            BEQEX: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_SUB;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ADDIWB: begin
                c.regwrite = 1'b1;
            end
            ORIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.aluop   = ALUOP_OR;
                c.zeroext = 1'b1;
            end
            ORIWB: begin
                c.regwrite = 1'b1;
                c.zeroext  = 1'b1;
            end
            JEX: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mainfsm.sv
// ---------------------------------------------------------------------------
// mainfsm
// Multicycle MIPS main control FSM. Steps each instruction through
// FETCH / DECODE / execute / memory / writeback and drives the datapath.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset, forces FETCH
//   op        in   opcode from instruction register
//   zero      in   ALU zero flag (used for beq)
//   pcen      out  pcwrite | (branch & zero)
//   memwrite  out  memory write enable
//   irwrite   out  instruction register load
//   regwrite  out  register file write
//   alusrca   out  0 = PC, 1 = register A
//   alusrcb   out  00 B, 01 const 4, 10 imm, 11 imm<<2
//   aluop     out  request to ALU decoder (add/sub/funct/or)
//   pcsrc     out  00 ALUResult, 01 ALUOut, 10 jump target
//   iord      out  0 PC address, 1 ALUOut address
//   memtoreg  out  writeback from memory data
//   regdst    out  1 rd, 0 rt
//   zeroext   out  zero-extend immediate (ori)
//   illegal   out  unrecognised opcode seen in DECODE
// ---------------------------------------------------------------------------
module mainfsm
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic           zero,
    output logic           pcen,
    output logic           memwrite,
    output logic           irwrite,
    output logic           regwrite,
    output logic           alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     aluop,
    output logic [1:0]     pcsrc,
    output logic           iord,
    output logic           memtoreg,
    output logic           regdst,
    output logic           zeroext,
    output logic           illegal
);

    statetype state_r;
    statetype state_s;
    ctrl_t    ctrl_r;
    logic     illegal_s;

    // Next-state selection and opcode legality check.
    always_comb begin
        state_s   = FETCH;
        illegal_s = 1'b0;
        case (state_r)
            FETCH: begin
                state_s = DECODE;
            end
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_s = MEMADR;
                    OP_RTYPE:     state_s = RTYPEEX;
                    OP_BEQ:       state_s = BEQEX;
                    OP_ADDI:      state_s = ADDIEX;
                    OP_ORI:       state_s = ORIEX;
                    OP_J:         state_s = JEX;
                    default: begin
                        state_s   = FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                if (op == OP_LW) begin
                    state_s = MEMRD;
                end else begin
                    state_s = MEMWR;
                end
            end
            MEMRD:   state_s = MEMWB;
            MEMWB:   state_s = FETCH;
            MEMWR:   state_s = FETCH;
            RTYPEEX: state_s = RTYPEWB;
            RTYPEWB: state_s = FETCH;
            BEQEX:   state_s = FETCH;
            ADDIEX:  state_s = ADDIWB;
            ADDIWB:  state_s = FETCH;
            ORIEX:   state_s = ORIWB;
            ORIWB:   state_s = FETCH;
            JEX:     state_s = FETCH;
            default: state_s = FETCH;
        endcase
    end

    // State register plus controls pre-decoded from the next state, so the
    // Moore outputs come straight from flops yet line up with state_r.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= FETCH;
            ctrl_r  <= state_ctrl(FETCH);
        end else begin
            state_r <= state_s;
            ctrl_r  <= state_ctrl(state_s);
        end
    end

    assign pcen     = ctrl_r.pcwrite | (ctrl_r.branch & zero);
    assign memwrite = ctrl_r.memwrite;
    assign irwrite  = ctrl_r.irwrite;
    assign regwrite = ctrl_r.regwrite;
    assign alusrca  = ctrl_r.alusrca;
    assign alusrcb  = ctrl_r.alusrcb;
    assign aluop    = ctrl_r.aluop;
    assign pcsrc    = ctrl_r.pcsrc;
    assign iord     = ctrl_r.iord;
    assign memtoreg = ctrl_r.memtoreg;
    assign regdst   = ctrl_r.regdst;
    assign zeroext  = ctrl_r.zeroext;
    assign illegal  = illegal_s;

endmodule

// File: tb/tb_mainfsm.sv
// ---------------------------------------------------------------------------
// tb_mainfsm
// Randomised instruction stream against an instruction-level reference
// model; expected per-cycle controls are queued by the driver and popped
// by an independent monitor on every falling edge.
// ---------------------------------------------------------------------------
module tb_mainfsm;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       iord, memtoreg, regdst, zeroext, illegal;

    typedef struct packed {
        logic       pcen;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       zeroext;
        logic       illegal;
    } ctl_t;

    typedef enum int { C_LW, C_SW, C_R, C_BEQ, C_ADDI, C_ORI, C_J, C_ILL } cls_t;

    ctl_t act;
    ctl_t exp_q[$];
    logic mon_en;
    int   n_checks;
    int   n_pass;

    mainfsm #(.OPW(6)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .pcsrc(pcsrc), .iord(iord), .memtoreg(memtoreg),
        .regdst(regdst), .zeroext(zeroext), .illegal(illegal)
    );

    assign act = {pcen, memwrite, irwrite, regwrite, alusrca, alusrcb,
                  aluop, pcsrc, iord, memtoreg, regdst, zeroext, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cls_t classify(input logic [5:0] o);
        case (o)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000000: return C_R;
            6'b000100: return C_BEQ;
            6'b001000: return C_ADDI;
            6'b001101: return C_ORI;
            6'b000010: return C_J;
            default:   return C_ILL;
        endcase
    endfunction

    // Instruction latency in cycles, FETCH included.
    function automatic int latency(input cls_t c);
        case (c)
            C_LW:    return 5;
            C_SW, C_R, C_ADDI, C_ORI: return 4;
            C_BEQ, C_J: return 3;
            default: return 2;
        endcase
    endfunction

    // Expected controls in cycle k of an instruction of class c.
    function automatic ctl_t model(input cls_t c, input int k, input logic z);
        ctl_t e;
        e = '0;
        if (k == 0) begin
            e.irwrite = 1'b1; e.pcen = 1'b1; e.alusrcb = 2'b01;
        end else if (k == 1) begin
            e.alusrcb = 2'b11;
            e.illegal = (c == C_ILL);
        end else begin
            case (c)
                C_LW: begin
                    if (k == 2) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
                    if (k == 3) e.iord = 1'b1;
                    if (k == 4) begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
                end
                C_SW: begin
                    if (k == 2) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
                    if (k == 3) begin e.iord = 1'b1; e.memwrite = 1'b1; end
                end
                C_R: begin
                    if (k == 2) begin e.alusrca = 1'b1; e.aluop = 2'b10; end
                    if (k == 3) begin e.regdst = 1'b1; e.regwrite = 1'b1; end
                end
                C_BEQ: begin
                    e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcen = z;
                end
                C_ADDI: begin
                    if (k == 2) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
                    if (k == 3) e.regwrite = 1'b1;
                end
                C_ORI: begin
                    if (k == 2) begin
                        e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluop = 2'b11; e.zeroext = 1'b1;
                    end
                    if (k == 3) begin e.regwrite = 1'b1; e.zeroext = 1'b1; end
                end
                C_J: begin
                    e.pcsrc = 2'b10; e.pcen = 1'b1;
                end
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    task automatic check(input string name, input ctl_t got, input ctl_t want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: one expected control vector per cycle while enabled.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow: got empty queue want entry at %0t", $time);
            end else begin
                check("cycle_ctrl", act, exp_q.pop_front());
            end
        end
    end

    // Entered at posedge+1 of the FETCH cycle; returns at posedge+1 of the
    // instruction's last cycle. zmode: 0/1 force zero, 2 random.
    task automatic run_instr(input logic [5:0] opv, input int zmode);
        cls_t c;
        int   lat;
        c   = classify(opv);
        lat = latency(c);
        for (int k = 0; k < lat; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            // op only matters in DECODE and MEMADR; scramble it elsewhere
            if (k == 1 || k == 2) op = opv;
            else op = 6'($urandom_range(0, 63));
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            exp_q.push_back(model(c, k, zero));
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] v;
        int r;
        logic [5:0] legal_ops [7];
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                      6'b001000, 6'b001101, 6'b000010};
        r = $urandom_range(0, 8);
        if (r < 7) return legal_ops[r];
        do v = 6'($urandom_range(0, 63)); while (classify(v) != C_ILL);
        return v;
    endfunction

    // Abort an lw in MEMRD with an asynchronous reset.
    task automatic reset_mid_lw();
        ctl_t fetch_v;
        fetch_v = model(C_LW, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) next_cycle();
            op = 6'b100011;
            zero = 1'b0;
            exp_q.push_back(model(C_LW, k, zero));
        end
        next_cycle();
        mon_en = 1'b0;
        check("memrd_before_reset", act, model(C_LW, 3, zero));
        #2 reset = 1'b1;
        #1 check("async_reset_fetch", act, fetch_v);
        @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        ctl_t fetch_v;
        n_checks = 0;
        n_pass   = 0;
        mon_en   = 1'b0;
        reset    = 1'b1;
        op       = 6'b000000;
        zero     = 1'b0;
        fetch_v  = model(C_LW, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1 check("reset_state", act, fetch_v);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Directed: lw, sw, beq taken/not, ori, R-type, illegal, addi, j
        run_instr(6'b100011, 2); next_cycle();
        run_instr(6'b101011, 2); next_cycle();
        run_instr(6'b000100, 1); next_cycle();
        run_instr(6'b000100, 0); next_cycle();
        run_instr(6'b001101, 2); next_cycle();
        run_instr(6'b000000, 2); next_cycle();
        run_instr(6'b111111, 2); next_cycle();
        run_instr(6'b001000, 2); next_cycle();
        run_instr(6'b000010, 2); next_cycle();

        reset_mid_lw();

        for (int i = 0; i < 150; i++) begin
            run_instr(rand_op(), 2);
            next_cycle();
        end
        reset_mid_lw();
        run_instr(6'b100011, 2);

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL sb_drain: got %0d entries want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
